config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter CFG_W, default 108: switch-block configuration width.
REQ-003 SHALL have parameter LB_W, default 5: logic-block configuration width, {sync, mem[3:0]}.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port bs_data  input  8  bitstream byte.
REQ-007 SHALL have port bs_valid  input  1  bs_data valid this cycle.
REQ-008 SHALL have port bs_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port sb_cfg  output  CFG_W  committed switch-block configuration.
REQ-010 SHALL have port lb_cfg  output  LB_W  committed logic-block configuration; [4]=sync, [3:0]=mem.
REQ-011 SHALL have port cfg_done  output  1  level: last frame committed successfully.
REQ-012 SHALL have port cfg_err  output  1  level: last frame failed checksum.

Function
REQ-013 SHALL accept a byte only on a rising edge where bs_valid and bs_ready are both 1.
REQ-014 SHALL implement FSM states IDLE, LOAD, CHECK, COMMIT.
REQ-015 SHALL, in IDLE, discard accepted bytes other than SYNC_BYTE; accepting SYNC_BYTE moves to LOAD, clears byte counter, shadow register, running checksum, cfg_done and cfg_err.
REQ-016 SHALL, in LOAD, accept exactly 15 payload bytes; payload byte k (k=0 first) is written to shadow[8k+7:8k] of a 120-bit shadow register and XORed into the running checksum.
REQ-017 SHALL move LOAD->CHECK on acceptance of payload byte 14; counter is 4 bits and never wraps.
REQ-018 SHALL, in CHECK, accept one checksum byte, compare it with the running XOR of the 15 payload bytes, latch the result, and move to COMMIT.
REQ-019 SHALL hold bs_ready=1 in IDLE, LOAD and CHECK, and bs_ready=0 in COMMIT.
REQ-020 SHALL stay in COMMIT exactly one cycle, then return to IDLE.
REQ-021 SHALL, on the COMMIT->IDLE edge after a match, load sb_cfg=shadow[CFG_W-1:0] and lb_cfg=shadow[CFG_W+LB_W-1:CFG_W], and set cfg_done=1.
REQ-022 SHALL, on the COMMIT->IDLE edge after a mismatch, leave sb_cfg and lb_cfg unchanged and set cfg_err=1.
REQ-023 SHALL ignore shadow[119:CFG_W+LB_W]; reserved bits do not affect commit or error.
REQ-024 SHALL treat SYNC_BYTE received in LOAD or CHECK as ordinary data; no resynchronisation mid-frame.
REQ-025 SHALL never assert cfg_done and cfg_err together.
REQ-026 SHALL keep sb_cfg and lb_cfg stable at all times except the single commit edge; no partial updates.
REQ-027 SHALL make a committed byte-k value visible on the outputs 2 edges after checksum acceptance.
REQ-028 SHALL tolerate bs_valid gaps of any length in any state without changing state or counter.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, counter=0, shadow=0, checksum=0, sb_cfg=0, lb_cfg=0, cfg_done=0, cfg_err=0, bs_ready=0.
REQ-030 SHALL, on rst assertion mid-frame, abandon the frame; outputs go to 0, not the previous commit.
REQ-031 SHALL drive bs_ready=1 from the first clk edge after rst deasserts.

Structure
REQ-032 SHALL place SYNC_BYTE, payload length (15), shadow width (120) and the FSM state encoding in shared package cfg_pkg, reused by the bitstream generator bench.
REQ-033 SHALL be a single module; no sub-module is required.

Verification
REQ-034 SHALL cover golden frame: A5, payload 10 00 04 00 48 00 10 00 00 00 00 00 00 60 00, checksum 2C -> sb_cfg bits 4,18,35,38,52 =1, others 0; lb_cfg=5'b00110; cfg_done=1, cfg_err=0.
REQ-035 SHALL cover a bad checksum: same frame with checksum 2D after a good commit -> cfg_err=1, cfg_done=0, sb_cfg and lb_cfg unchanged.
REQ-036 SHALL cover garbage before sync: bytes 00 FF 5A, then the golden frame -> identical result to REQ-034; garbage changes nothing.
REQ-037 SHALL cover bs_valid toggled every other cycle through the golden frame -> same result; bs_ready=0 for exactly 1 cycle (COMMIT).
REQ-038 SHALL cover rst pulsed after payload byte 7 -> all outputs 0; a following golden frame commits normally.
REQ-039 SHALL cover a payload containing byte A5 at k=3 with correct checksum -> commit succeeds, shadow[31:24]=A5.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the configuration bitstream loader.
// The bitstream generator bench uses the same definitions.
package cfg_pkg;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam int unsigned PAYLOAD_LEN  = 15;
    localparam int unsigned SHADOW_W     = 120;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/config_loader.sv
// Bitstream configuration loader: hunts for a sync byte, shadows a 15-byte payload,
// verifies an XOR checksum and commits the switch/logic-block configuration atomically.
module config_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter int unsigned CFG_W     = 108,
    parameter int unsigned LB_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bs_data,
    input  logic             bs_valid,
    output logic             bs_ready,
    output logic [CFG_W-1:0] sb_cfg,
    output logic [LB_W-1:0]  lb_cfg,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int unsigned     KEEP_W   = CFG_W + LB_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [KEEP_W-1:0]  shadow;
    logic [7:0]         csum;
    logic               match;
    logic               accept_c;

    assign accept_c = bs_valid & bs_ready;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c && (bs_data == SYNC_BYTE)) state_nx = LOAD;
            LOAD:    if (accept_c && (cnt == LAST_IDX))      state_nx = CHECK;
            CHECK:   if (accept_c)                           state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Datapath; reserved shadow bits above KEEP_W can never reach an output, so they are not stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs_ready <= 1'b0;
            cnt      <= '0;
            shadow   <= '0;
            csum     <= '0;
            match    <= 1'b0;
            sb_cfg   <= '0;
            lb_cfg   <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            bs_ready <= (state_nx != COMMIT);
            case (state)
                IDLE: begin
                    if (accept_c && (bs_data == SYNC_BYTE)) begin
                        cnt      <= '0;
                        shadow   <= '0;
                        csum     <= '0;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        for (int unsigned i = 0; i < KEEP_W; i++) begin
                            if (CNT_W'(i / 8) == cnt) shadow[i] <= bs_data[3'(i % 8)];
                        end
                        csum <= csum ^ bs_data;
                        if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (accept_c) match <= (bs_data == csum);
                end
                COMMIT: begin
                    if (match) begin
                        sb_cfg   <= shadow[CFG_W-1:0];
                        lb_cfg   <= shadow[KEEP_W-1:CFG_W];
                        cfg_done <= 1'b1;
                    end else begin
                        cfg_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: queue-based frame model checked every cycle, directed
// golden/bad/garbage/gap/reset frames plus randomized traffic.
module tb_config_loader;
    import cfg_pkg::*;

    localparam int unsigned CFG_W = 108;
    localparam int unsigned LB_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       bs_data;
    logic             bs_valid;
    logic             bs_ready;
    logic [CFG_W-1:0] sb_cfg;
    logic [LB_W-1:0]  lb_cfg;
    logic             cfg_done;
    logic             cfg_err;

    always #5 clk = ~clk;

    config_loader #(.SYNC_BYTE(8'hA5), .CFG_W(CFG_W), .LB_W(LB_W)) dut (
        .clk(clk), .rst(rst), .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .sb_cfg(sb_cfg), .lb_cfg(lb_cfg), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ready_low   = 0;
    bit started     = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: a byte queue between sync and checksum
    logic [7:0]          frame_q [$];
    bit                  in_frame = 0, pending = 0, m_ready = 0, m_done = 0, m_err = 0, m_acc;
    logic [CFG_W-1:0]    m_sb = '0;
    logic [LB_W-1:0]     m_lb = '0;
    logic [SHADOW_W-1:0] m_vec;
    logic [7:0]          m_x;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            in_frame = 0; pending = 0; m_ready = 0; m_done = 0; m_err = 0;
            m_sb = '0; m_lb = '0;
        end else begin
            m_acc = bs_valid && m_ready;
            if (pending) begin
                m_x = '0;
                for (int i = 0; i < PAYLOAD_LEN; i++) m_x ^= frame_q[i];
                if (m_x == frame_q[PAYLOAD_LEN]) begin
                    m_vec = '0;
                    for (int i = 0; i < PAYLOAD_LEN; i++) m_vec[8*i +: 8] = frame_q[i];
                    m_sb   = m_vec[CFG_W-1:0];
                    m_lb   = m_vec[CFG_W+LB_W-1:CFG_W];
                    m_done = 1;
                end else begin
                    m_err = 1;
                end
                pending = 0;
            end else if (m_acc) begin
                if (!in_frame) begin
                    if (bs_data == SYNC_DEFAULT) begin
                        in_frame = 1; frame_q.delete(); m_done = 0; m_err = 0;
                    end
                end else begin
                    frame_q.push_back(bs_data);
                    if (frame_q.size() == PAYLOAD_LEN + 1) begin
                        pending = 1; in_frame = 0;
                    end
                end
            end
            m_ready = !pending;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("bs_ready", 128'(bs_ready), 128'(m_ready));
            chk("sb_cfg",   128'(sb_cfg),   128'(m_sb));
            chk("lb_cfg",   128'(lb_cfg),   128'(m_lb));
            chk("cfg_done", 128'(cfg_done), 128'(m_done));
            chk("cfg_err",  128'(cfg_err),  128'(m_err));
            chk("done_err_exclusive", 128'(cfg_done && cfg_err), 128'(0));
            if (!rst && !bs_ready) ready_low++;
        end
    end

    // Present one byte (after 'gap' idle cycles) and hold it until accepted
    task automatic send(input logic [7:0] b, input int gap);
        bit acc;
        int t = 0;
        repeat (gap) begin
            bs_valid = 1'b0;
            @(posedge clk); #1;
        end
        bs_valid = 1'b1;
        bs_data  = b;
        forever begin
            acc = bs_ready;
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 40) begin
                chk("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        bs_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] p [15], input logic [7:0] ck, input int gap, input bit rnd_gap);
        send(SYNC_DEFAULT, rnd_gap ? int'($urandom_range(0, 2)) : gap);
        for (int i = 0; i < PAYLOAD_LEN; i++) send(p[i], rnd_gap ? int'($urandom_range(0, 2)) : gap);
        send(ck, rnd_gap ? int'($urandom_range(0, 2)) : gap);
    endtask

    // Wait through COMMIT, check the committed result against literals, realign to posedge+1
    task automatic check_result(input string tag, input logic [CFG_W-1:0] esb, input logic [LB_W-1:0] elb,
                                input bit edone, input bit eerr);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_sb"},   128'(sb_cfg),   128'(esb));
        chk({tag, "_lb"},   128'(lb_cfg),   128'(elb));
        chk({tag, "_done"}, 128'(cfg_done), 128'(edone));
        chk({tag, "_err"},  128'(cfg_err),  128'(eerr));
        chk({tag, "_model_sb"}, 128'(m_sb), 128'(esb));
        chk({tag, "_model_lb"}, 128'(m_lb), 128'(elb));
        @(posedge clk); #1;
    endtask

    logic [7:0]       gold [15];
    logic [7:0]       pa   [15];
    logic [7:0]       rp   [15];
    logic [CFG_W-1:0] gold_sb;
    logic [CFG_W-1:0] exp_sb;
    logic [7:0]       ck;

    initial begin
        rst = 1'b0; bs_valid = 1'b0; bs_data = '0;
        gold = '{8'h10, 8'h00, 8'h04, 8'h00, 8'h48, 8'h00, 8'h10, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'h00};
        gold_sb = '0;
        gold_sb[4] = 1'b1; gold_sb[18] = 1'b1; gold_sb[35] = 1'b1; gold_sb[38] = 1'b1; gold_sb[52] = 1'b1;

        #1 rst = 1'b1;
        #1 started = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_low", 128'(bs_ready), 128'(0));
        chk("reset_sb",        128'(sb_cfg),   128'(0));
        chk("reset_done",      128'(cfg_done), 128'(0));
        @(negedge clk);
        chk("ready_after_reset", 128'(bs_ready), 128'(1));
        @(posedge clk); #1;

        // Golden frame
        send_frame(gold, 8'h2C, 0, 0);
        check_result("golden", gold_sb, 5'b00110, 1, 0);

        // Bad checksum keeps the previous commit
        send_frame(gold, 8'h2D, 0, 0);
        check_result("badck", gold_sb, 5'b00110, 0, 1);

        // Garbage ahead of sync
        send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
        chk("garbage_err_kept", 128'(cfg_err), 128'(1));
        send_frame(gold, 8'h2C, 0, 0);
        check_result("garbage", gold_sb, 5'b00110, 1, 0);

        // bs_valid every other cycle; ready drops only for the COMMIT cycle
        repeat (2) @(posedge clk); #1;
        ready_low = 0;
        send_frame(gold, 8'h2C, 1, 0);
        check_result("toggle", gold_sb, 5'b00110, 1, 0);
        repeat (3) @(posedge clk); #1;
        chk("toggle_ready_low_cycles", 128'(ready_low), 128'(1));

        // Reset after payload byte 7
        send(SYNC_DEFAULT, 0);
        for (int i = 0; i < 8; i++) send(gold[i], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_sb",   128'(sb_cfg),   128'(0));
        chk("midreset_lb",   128'(lb_cfg),   128'(0));
        chk("midreset_done", 128'(cfg_done), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(gold, 8'h2C, 0, 0);
        check_result("after_reset", gold_sb, 5'b00110, 1, 0);

        // Sync value inside the payload is plain data
        pa = gold;
        pa[3] = 8'hA5;
        exp_sb = gold_sb;
        exp_sb[31:24] = 8'hA5;
        send_frame(pa, 8'h89, 0, 0);
        check_result("sync_in_payload", exp_sb, 5'b00110, 1, 0);
        chk("sync_in_payload_byte3", 128'(sb_cfg[31:24]), 128'(8'hA5));

        // Randomized traffic against the model
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) send(8'($urandom), int'($urandom_range(0, 2)));
            ck = '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                rp[i] = 8'($urandom);
                ck ^= rp[i];
            end
            if ($urandom_range(0, 3) == 0) ck ^= 8'($urandom_range(1, 255));
            if ($urandom_range(0, 7) == 0) begin
                send(SYNC_DEFAULT, 0);
                repeat ($urandom_range(0, 14)) send(8'($urandom), int'($urandom_range(0, 2)));
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1 rst = 1'b0;
            end
            send_frame(rp, ck, 0, 1);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
